// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter
// Round-robin front end that shares one pipelined 8x8 multiplier among NREQ
// requesters. Each issued operand pair carries its requester ID down a LAT-deep
// tag pipeline. The result is captured into a DEPTH-entry response FIFO, which
// has a valid/ready output.
//
// The credit scheme allows an issue only while the FIFO entries plus the ops in
// flight total less than DEPTH. Every op that is in flight therefore already
// owns a FIFO slot.
//
// mul_product is sampled in the cycle in which tag stage LAT-1 holds the op.
// That cycle comes LAT-1 clock edges after mul_a/mul_b were registered.
module approx_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_product,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_product,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + LAT + 1);

  // round-robin pointer: last granted requester
  logic [IDW-1:0] ptr_q, ptr_d;

  // operand registers feeding the multiplier
  logic [7:0] mul_a_q, mul_a_d;
  logic [7:0] mul_b_q, mul_b_d;

  // tag pipeline
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [IDW-1:0] tag_id_d [LAT];

  // response FIFO
  logic [IDW-1:0] fid_q   [DEPTH];
  logic [IDW-1:0] fid_d   [DEPTH];
  logic [15:0]    fprod_q [DEPTH];
  logic [15:0]    fprod_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  // arbitration / credit
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [OW-1:0]  inflight;
  logic [OW-1:0]  occ;
  logic           issue_ok;
  logic           hs;
  logic [7:0]     win_a;
  logic [7:0]     win_b;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pick the first valid requester after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Ops in flight plus FIFO entries are the slots already spoken for.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + OW'(tag_vld_q[i]);
    end
    occ      = OW'(count_q) + inflight;
    issue_ok = (occ < OW'(DEPTH));
  end

  // Grant and operand mux; at most one ready bit, held low during reset.
  always_comb begin
    hs        = win_found && issue_ok && !rst;
    req_ready = '0;
    if (hs) begin
      req_ready[win_id] = 1'b1;
    end
    win_a   = req_a[{win_id, 3'b000} +: 8];
    win_b   = req_b[{win_id, 3'b000} +: 8];
    mul_a_d = hs ? win_a : mul_a_q;
    mul_b_d = hs ? win_b : mul_b_q;
    ptr_d   = hs ? win_id : ptr_q;
  end

  // Tag pipeline shifts every cycle; stage 0 is loaded only on a handshake.
  always_comb begin
    tag_vld_d[0] = hs;
    tag_id_d[0]  = win_id;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // FIFO next state: the last tag stage pushes, and the consumer handshake pops.
  always_comb begin
    push     = tag_vld_q[LAT-1];
    pop      = rsp_ready && (count_q != '0);
    fid_d    = fid_q;
    fprod_d  = fprod_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fid_d[wr_ptr_q]   = tag_id_q[LAT-1];
      fprod_d[wr_ptr_q] = mul_product;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= IDW'(NREQ - 1);
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fid_q[i]   <= '0;
        fprod_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      fid_q     <= fid_d;
      fprod_q   <= fprod_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // A push into a full FIFO would overwrite the head; credits must prevent it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end

  // While the FIFO is empty the head reads as zero, so the reset values are defined.
  always_comb begin
    rsp_valid   = (count_q != '0);
    rsp_id      = rsp_valid ? fid_q[rd_ptr_q]   : '0;
    rsp_product = rsp_valid ? fprod_q[rd_ptr_q] : '0;
    busy        = (|tag_vld_q) || rsp_valid;
    mul_a       = mul_a_q;
    mul_b       = mul_b_q;
  end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb_approx_mul_arbiter
// Directed bench for approx_mul_arbiter. It uses a one-register stub multiplier
// (LAT=2) that returns a*b. The monitor runs on each falling edge and predicts
// the grant, busy and the response stream from its own arbiter/credit model.
// It holds the expected responses in a queue.
module tb_approx_mul_arbiter;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_product;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_product;
  logic              busy;

  always #5 clk = ~clk;

  approx_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy)
  );

  // Stub multiplier: one register after the operand flops.
  logic [15:0] prod_q;
  always @(posedge clk) prod_q <= 16'(mul_a) * 16'(mul_b);
  assign mul_product = prod_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t            sb[$];
  exp_t            e;
  bit              mon_en = 1'b0;
  int              cyc = 0;
  int              m_ptr = NREQ - 1;
  int              pops = 0;
  bit              exp_found;
  int              exp_win;
  bit              exp_issue;
  logic [NREQ-1:0] exp_ready;
  logic [IDW-1:0]  mcb;
  bit              head_vis;

  // Reference model and scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_found = 1'b0;
      exp_win   = 0;
      for (int k = 1; k <= NREQ; k++) begin
        mcb = IDW'((m_ptr + k) % NREQ);
        if (!exp_found && req_valid[mcb]) begin
          exp_found = 1'b1;
          exp_win   = int'(mcb);
        end
      end
      exp_issue = exp_found && (sb.size() < DEPTH) && !rst;
      exp_ready = exp_issue ? (NREQ'(1) << exp_win) : '0;
      check("grant", req_ready, exp_ready);
      check("busy", busy, sb.size() != 0);
      head_vis = (sb.size() != 0) && (sb[0].due <= cyc);
      check("rsp_valid", rsp_valid, head_vis);
      if (head_vis) begin
        check("rsp_id", rsp_id, sb[0].id);
        check("rsp_product", rsp_product, sb[0].prod);
        if (rsp_ready) begin
          void'(sb.pop_front());
          pops++;
        end
      end
      if (exp_issue) begin
        e.id   = exp_win;
        e.prod = 16'(8'(req_a >> (8 * exp_win))) * 16'(8'(req_b >> (8 * exp_win)));
        e.due  = cyc + LAT + 1;
        sb.push_back(e);
        m_ptr = exp_win;
      end
      if (rst) begin
        sb.delete();
        m_ptr = NREQ - 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout", busy, 1'b0);
  endtask

  int n;
  int p0;
  int hs;
  logic [NREQ-1:0] t5_exp [4];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    // reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: single op
    rsp_ready = 1'b1;
    set_ops(0, 8'd3, 8'd5);
    req_valid = 4'b0001;
    #1;
    check("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("t1_latency", n, LAT);
    check("t1_id", rsp_id, 0);
    check("t1_product", rsp_product, 15);
    tick();
    check("t1_busy_after_pop", busy, 0);
    check("t1_rsp_valid_after_pop", rsp_valid, 0);

    // 2: all requesters streaming
    p0 = pops;
    req_valid = 4'b1111;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, 8'(r * 4 + i + 1), 8'(i + 7));
      tick();
    end
    req_valid = '0;
    repeat (LAT) tick();
    check("t2_done_minus1", pops - p0, 15);
    tick();
    check("t2_completed", pops - p0, 16);
    drain();

    // 3: backpressure
    rsp_ready = 1'b0;
    hs = 0;
    set_ops(1, 8'd1, 8'd1);
    req_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_ready[1]) hs++;
      tick();
      set_ops(1, 8'(hs + 1), 8'(hs + 1));
    end
    check("t3_handshakes", hs, DEPTH);
    #1;
    check("t3_stalled", req_ready, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_ready[1]) hs++;
      tick();
      set_ops(1, 8'(hs + 1), 8'(hs + 1));
    end
    req_valid = '0;
    drain();

    // 4: fill, then random pop pattern with simultaneous push/pop
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      set_ops(2, 8'($urandom), 8'($urandom));
      tick();
    end
    check("t4_full_busy", busy, 1);
    for (int i = 0; i < 40; i++) begin
      set_ops(2, 8'($urandom), 8'($urandom));
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // 5: fairness from ptr=0
    set_ops(0, 8'd2, 8'd2);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    drain();
    set_ops(0, 8'd10, 8'd11);
    set_ops(2, 8'd12, 8'd13);
    t5_exp[0] = 4'b0100;
    t5_exp[1] = 4'b0001;
    t5_exp[2] = 4'b0100;
    t5_exp[3] = 4'b0001;
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_grant", req_ready, t5_exp[i]);
      tick();
    end
    req_valid = '0;
    drain();

    // 6: reset with ops queued and in flight
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      set_ops(3, 8'(20 + i), 8'(3));
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    set_ops(3, 8'd50, 8'd2);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    #1;
    check("t6_busy_before", busy, 1);
    check("t6_valid_before", rsp_valid, 1);
    rst = 1'b1;
    tick();
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_req_ready", req_ready, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) begin
      tick();
      check("t6_no_ghost", rsp_valid, 0);
    end
    set_ops(0, 8'd9, 8'd9);
    set_ops(3, 8'd2, 8'd2);
    req_valid = 4'b1001;
    #1;
    check("t6_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
